// File: rtl/seg_scan_driver_if.sv
// Frame handoff between the control/status logic (master) and the seven-segment scan driver (slave).
interface seg_scan_driver_if;
    logic        load;
    logic [15:0] value;
    logic [3:0]  blank;
    logic [3:0]  dp_in;
    logic        ready;
    logic        frame_tick;

    modport master (output load, value, blank, dp_in, input  ready, frame_tick);
    modport slave  (input  load, value, blank, dp_in, output ready, frame_tick);
endinterface

// File: rtl/seg_scan_driver.sv
// Four-digit common-anode seven-segment scanner with hex decode, per-slot anti-ghost
// blanking and a single shadow frame that is only applied on a frame boundary.
module seg_scan_driver #(
    parameter int CLK_DIV      = 25_000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    seg_scan_driver_if.slave frame_if,
    output logic [6:0]       seg,
    output logic [3:0]       an,
    output logic             dp
);
    localparam int CNT_W = $clog2(CLK_DIV);

    // state    | meaning
    // SH_EMPTY | no pending frame; ready is high and the next load is taken
    // SH_FULL  | frame waiting in the shadow; copied to active at the next frame boundary
    typedef enum logic {SH_EMPTY = 1'b0, SH_FULL = 1'b1} sh_state_t;

    sh_state_t        sh_state;
    sh_state_t        sh_state_nxt;
    logic [CNT_W-1:0] slot_cnt;
    logic [1:0]       dig_idx;
    logic             slot_wrap;
    logic             frame_bnd;
    logic             accept;
    logic             apply;
    logic             tick_q;
    logic [15:0]      sh_value;
    logic [3:0]       sh_blank;
    logic [3:0]       sh_dp;
    logic [15:0]      act_value;
    logic [3:0]       act_blank;
    logic [3:0]       act_dp;
    logic [3:0]       nibble;
    logic             lit;
    logic [6:0]       seg_nxt;
    logic [3:0]       an_nxt;
    logic             dp_nxt;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign slot_wrap = (slot_cnt == CNT_W'(CLK_DIV - 1));
    assign frame_bnd = slot_wrap && (dig_idx == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt <= '0;
            dig_idx  <= '0;
        end else if (slot_wrap) begin
            slot_cnt <= '0;
            dig_idx  <= dig_idx + 2'd1;
        end else begin
            slot_cnt <= slot_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) sh_state <= SH_EMPTY;
        else     sh_state <= sh_state_nxt;
    end

    // A load landing on the boundary cycle only fills the shadow; it waits a whole frame.
    always_comb begin
        sh_state_nxt = sh_state;
        case (sh_state)
            SH_EMPTY: if (frame_if.load) sh_state_nxt = SH_FULL;
            SH_FULL:  if (frame_bnd)     sh_state_nxt = SH_EMPTY;
            default:                     sh_state_nxt = SH_EMPTY;
        endcase
    end

    always_comb begin
        accept         = (sh_state == SH_EMPTY) && frame_if.load;
        apply          = (sh_state == SH_FULL) && frame_bnd;
        frame_if.ready = (sh_state == SH_EMPTY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_value  <= '0;
            sh_blank  <= '0;
            sh_dp     <= '0;
            act_value <= '0;
            act_blank <= 4'hF;
            act_dp    <= '0;
            tick_q    <= 1'b0;
        end else begin
            if (accept) begin
                sh_value <= frame_if.value;
                sh_blank <= frame_if.blank;
                sh_dp    <= frame_if.dp_in;
            end
            if (apply) begin
                act_value <= sh_value;
                act_blank <= sh_blank;
                act_dp    <= sh_dp;
            end
            tick_q <= apply;
        end
    end

    assign frame_if.frame_tick = tick_q;

    always_comb begin
        nibble  = act_value[{dig_idx, 2'b00} +: 4];
        lit     = (slot_cnt >= CNT_W'(BLANK_CYCLES)) && !act_blank[dig_idx];
        an_nxt  = lit ? ~(4'b0001 << dig_idx) : 4'hF;
        seg_nxt = lit ? hex_to_seg(nibble) : 7'h7F;
        dp_nxt  = lit ? ~act_dp[dig_idx] : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 4'hF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= dp_nxt;
        end
    end
endmodule
